// File: rtl/regfile_writeback.sv
// regfile_writeback: post-reset register clear sweep, then an in-order writeback FIFO draining into the register file.
// Optional forwarding of pending values when REGFILE_WB_BYPASS_EN is defined.
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [63:0]              in_data,
    output logic [4:0]               RD,
    output logic [63:0]              WriteData,
    output logic                     RegWrite,
    input  logic [4:0]               q_rs1,
    input  logic [4:0]               q_rs2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic                     fwd1_valid,
    output logic [63:0]              fwd1_data,
    output logic                     fwd2_valid,
    output logic [63:0]              fwd2_data
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state;
    logic [4:0] idx;
    logic [AW-1:0] rp, wp;
    logic [4:0] rd_mem [DEPTH];
    logic [63:0] data_mem [DEPTH];
    logic push, pop, hit1, hit2;
    assign busy = state == CLEAR;
    assign in_ready = state == RUN && count < CW'(DEPTH);
    assign push = in_valid && in_ready && in_rd != 5'd0;
    assign pop = count != '0;
    // idx wraps from 31 to 0, which marks the sweep as finished
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            idx <= 5'd1;
            rp <= '0;
            wp <= '0;
            count <= '0;
            RegWrite <= 1'b0;
            RD <= '0;
            WriteData <= '0;
        end else if (state == CLEAR) begin
            RegWrite <= idx != 5'd0;
            if (idx != 5'd0) begin
                RD <= idx;
                WriteData <= '0;
                idx <= idx + 5'd1;
            end else begin
                state <= RUN;
            end
        end else begin
            if (push) begin
                rd_mem[wp] <= in_rd;
                data_mem[wp] <= in_data;
                wp <= wp + 1'b1;
            end
            RegWrite <= pop;
            if (pop) begin
                RD <= rd_mem[rp];
                WriteData <= data_mem[rp];
                rp <= rp + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_comb begin
        hit1 = RegWrite && RD == q_rs1;
        hit2 = RegWrite && RD == q_rs2;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                hit1 = hit1 || rd_mem[rp + AW'(i)] == q_rs1;
                hit2 = hit2 || rd_mem[rp + AW'(i)] == q_rs2;
            end
        end
        hazard1 = !busy && q_rs1 != 5'd0 && hit1;
        hazard2 = !busy && q_rs2 != 5'd0 && hit2;
    end
`ifdef REGFILE_WB_BYPASS_EN
    // later FIFO slots are younger, so the last match wins over the outgoing write
    always_comb begin
        fwd1_data = WriteData;
        fwd2_data = WriteData;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && rd_mem[rp + AW'(i)] == q_rs1) fwd1_data = data_mem[rp + AW'(i)];
            if (CW'(i) < count && rd_mem[rp + AW'(i)] == q_rs2) fwd2_data = data_mem[rp + AW'(i)];
        end
        fwd1_valid = hazard1;
        fwd2_valid = hazard2;
    end
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed and random stimulus checked against a queue-based reference model.
module tb_regfile_writeback;
    localparam int DEPTH = 4;
    logic clk = 0, reset = 0, in_valid = 0;
    logic in_ready, RegWrite, hazard1, hazard2, busy;
    logic [4:0] in_rd = 0, q_rs1 = 0, q_rs2 = 0, RD;
    logic [63:0] in_data = 0, WriteData;
    logic [$clog2(DEPTH):0] count;
`ifdef REGFILE_WB_BYPASS_EN
    logic fwd1_valid, fwd2_valid;
    logic [63:0] fwd1_data, fwd2_data;
`endif
    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .RD(RD), .WriteData(WriteData),
        .RegWrite(RegWrite), .q_rs1(q_rs1), .q_rs2(q_rs2), .hazard1(hazard1),
        .hazard2(hazard2), .busy(busy), .count(count)
`ifdef REGFILE_WB_BYPASS_EN
        , .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
        .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data)
`endif
    );
    always #5 clk = ~clk;
    typedef struct {logic [4:0] rd; logic [63:0] d;} ent_t;
    ent_t mq[$];
    bit m_clear, m_rw, chk_en;
    int m_nxt;
    logic [4:0] m_rd;
    logic [63:0] m_wd;
    int n_chk = 0, n_fail = 0;
    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic bit m_haz(logic [4:0] r);
        if (m_clear || r == 0) return 0;
        if (m_rw && m_rd == r) return 1;
        foreach (mq[i]) if (mq[i].rd == r) return 1;
        return 0;
    endfunction
    function automatic logic [63:0] m_fwd(logic [4:0] r);
        logic [63:0] v = m_wd;
        foreach (mq[i]) if (mq[i].rd == r) v = mq[i].d;
        return v;
    endfunction
    task automatic step(bit r, bit v, logic [4:0] rd, logic [63:0] d, logic [4:0] a, logic [4:0] b);
        @(negedge clk);
        reset = r; in_valid = v; in_rd = rd; in_data = d; q_rs1 = a; q_rs2 = b;
        #1;
        if (chk_en) begin
            check("RegWrite", RegWrite, m_rw);
            if (m_rw) begin
                check("RD", RD, m_rd);
                check("WriteData", WriteData, m_wd);
            end
            check("busy", busy, m_clear);
            check("in_ready", in_ready, !m_clear && mq.size() < DEPTH);
            check("count", count, mq.size());
            check("hazard1", hazard1, m_haz(a));
            check("hazard2", hazard2, m_haz(b));
`ifdef REGFILE_WB_BYPASS_EN
            check("fwd1_valid", fwd1_valid, m_haz(a));
            check("fwd2_valid", fwd2_valid, m_haz(b));
            if (m_haz(a)) check("fwd1_data", fwd1_data, m_fwd(a));
            if (m_haz(b)) check("fwd2_data", fwd2_data, m_fwd(b));
`endif
        end
        if (r) begin
            mq.delete();
            m_rw = 0; m_rd = 0; m_wd = 0; m_clear = 1; m_nxt = 1;
        end else if (m_clear) begin
            if (m_nxt <= 31) begin
                m_rw = 1; m_rd = 5'(m_nxt); m_wd = 0; m_nxt++;
            end else begin
                m_clear = 0; m_rw = 0;
            end
        end else begin
            bit acc = v && mq.size() < DEPTH;
            if (mq.size() > 0) begin
                ent_t e = mq.pop_front();
                m_rw = 1; m_rd = e.rd; m_wd = e.d;
            end else m_rw = 0;
            if (acc && rd != 0) mq.push_back('{rd, d});
        end
    endtask
    initial begin
        step(1, 0, 0, 0, 0, 0);
        chk_en = 1;
        repeat (34) step(0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 64'hA5, 7, 5);
        step(0, 1, 7, 64'h3C, 7, 5);
        repeat (3) step(0, 0, 0, 0, 7, 5);
        for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 5'(i + 1), 64'(i * 17 + 3), 5'(i + 1), 5'(i));
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 64'hFFFF, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        step(0, 1, 3, 1, 3, 0);
        step(0, 1, 4, 2, 4, 3);
        step(0, 1, 6, 3, 6, 4);
        step(1, 0, 0, 0, 6, 4);
        repeat (34) step(0, 0, 0, 0, 6, 4);
        step(0, 1, 9, 1, 0, 9);
        step(0, 1, 9, 2, 0, 9);
        repeat (2) step(0, 0, 0, 0, 9, 9);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 60) == 0, 1'($urandom), 5'($urandom_range(0, 7)),
                 {$urandom, $urandom}, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
